// File: rtl/option_filter.sv
// option_filter: streams candidate options for one nonogram line, returns keep/drop
// verdicts and end-of-pass consensus deductions. Optional OPTION_FILTER_STATS_EN adds drop/stall counters.
module option_filter #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SIZE-1:0]  known,
  input  logic [SIZE-1:0]  assigned,
  input  logic             opt_valid,
  input  logic [SIZE-1:0]  opt_data,
  input  logic             opt_last,
  output logic             opt_ready,
  output logic             keep_valid,
  output logic             keep,
  input  logic             keep_ready,
  output logic             busy,
  output logic             done,
  output logic [SIZE-1:0]  new_known,
  output logic [SIZE-1:0]  new_assigned,
  output logic [CNT_W-1:0] survivors,
`ifdef OPTION_FILTER_STATS_EN
  output logic [CNT_W-1:0] dropped,
  output logic [15:0]      stall_cycles,
`endif
  output logic             unsat
);
  localparam logic [1:0] IDLE = 2'd0, FILTER = 2'd1, FINISH = 2'd2;
  logic [1:0] state_q, state_d;
  logic [SIZE-1:0] known_q, known_d, assigned_q, assigned_d, acc_one_q, acc_one_d, acc_zero_q, acc_zero_d;
  logic [SIZE-1:0] new_known_q, new_known_d, new_assigned_q, new_assigned_d;
  logic [CNT_W-1:0] count_q, count_d, survivors_q, survivors_d;
  logic keep_valid_q, keep_valid_d, keep_q, keep_d, done_q, done_d, unsat_q, unsat_d;
  logic take, xfer, contra, kept, fin, nz;
  assign opt_ready = (state_q == FILTER) && (!keep_valid_q || keep_ready);
  assign xfer      = opt_valid && opt_ready;
  assign contra    = |((assigned_q ^ opt_data) & known_q);
  assign kept      = xfer && !contra;
  // A pending verdict blocks a new pass so verdict order across passes is preserved
  assign take      = (state_q == IDLE) && start && !keep_valid_q;
  assign fin       = state_q == FINISH;
  assign nz        = count_q != '0;
  always_comb begin
    state_d        = take ? FILTER : (xfer && opt_last) ? FINISH : fin ? IDLE : state_q;
    known_d        = take ? known : known_q;
    assigned_d     = take ? assigned : assigned_q;
    acc_one_d      = take ? '1 : kept ? acc_one_q & opt_data : acc_one_q;
    acc_zero_d     = take ? '1 : kept ? acc_zero_q & ~opt_data : acc_zero_q;
    count_d        = take ? '0 : (kept && count_q != '1) ? count_q + CNT_W'(1) : count_q;
    keep_valid_d   = xfer || (keep_valid_q && !keep_ready);
    keep_d         = xfer ? !contra : keep_q;
    done_d         = fin;
    new_known_d    = fin ? (nz ? known_q | acc_one_q | acc_zero_q : known_q) : new_known_q;
    new_assigned_d = fin ? (assigned_q & known_q) | (nz ? acc_one_q & ~known_q : '0) : new_assigned_q;
    survivors_d    = fin ? count_q : survivors_q;
    unsat_d        = fin ? !nz : unsat_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      known_q        <= '0;
      assigned_q     <= '0;
      acc_one_q      <= '0;
      acc_zero_q     <= '0;
      count_q        <= '0;
      keep_valid_q   <= 1'b0;
      keep_q         <= 1'b0;
      done_q         <= 1'b0;
      new_known_q    <= '0;
      new_assigned_q <= '0;
      survivors_q    <= '0;
      unsat_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      known_q        <= known_d;
      assigned_q     <= assigned_d;
      acc_one_q      <= acc_one_d;
      acc_zero_q     <= acc_zero_d;
      count_q        <= count_d;
      keep_valid_q   <= keep_valid_d;
      keep_q         <= keep_d;
      done_q         <= done_d;
      new_known_q    <= new_known_d;
      new_assigned_q <= new_assigned_d;
      survivors_q    <= survivors_d;
      unsat_q        <= unsat_d;
    end
  end
  assign keep_valid   = keep_valid_q;
  assign keep         = keep_q;
  assign busy         = state_q != IDLE;
  assign done         = done_q;
  assign new_known    = new_known_q;
  assign new_assigned = new_assigned_q;
  assign survivors    = survivors_q;
  assign unsat        = unsat_q;
`ifdef OPTION_FILTER_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, dropped_q, dropped_d;
  logic [15:0] stall_q, stall_d;
  always_comb begin
    drop_cnt_d = take ? '0 : (xfer && contra && drop_cnt_q != '1) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    dropped_d  = fin ? drop_cnt_q : dropped_q;
    stall_d    = take ? '0 : (state_q == FILTER && opt_valid && !opt_ready && stall_q != '1) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
      dropped_q  <= '0;
      stall_q    <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      dropped_q  <= dropped_d;
      stall_q    <= stall_d;
    end
  end
  assign dropped      = dropped_q;
  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_option_filter.sv
// tb_option_filter: directed checks of option_filter verdicts, deductions, backpressure and reset.
module tb_option_filter;
  localparam int SIZE = 4, CNT_W = 3;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, opt_valid = 1'b0, opt_last = 1'b0, keep_ready = 1'b1;
  logic [SIZE-1:0] known = '0, assigned = '0, opt_data = '0;
  logic opt_ready, keep_valid, keep, busy, done, unsat;
  logic [SIZE-1:0] new_known, new_assigned;
  logic [CNT_W-1:0] survivors;
`ifdef OPTION_FILTER_STATS_EN
  logic [CNT_W-1:0] dropped;
  logic [15:0] stall_cycles;
`endif
  int checks = 0, failures = 0;

  option_filter #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .known(known), .assigned(assigned),
    .opt_valid(opt_valid), .opt_data(opt_data), .opt_last(opt_last), .opt_ready(opt_ready),
    .keep_valid(keep_valid), .keep(keep), .keep_ready(keep_ready), .busy(busy), .done(done),
    .new_known(new_known), .new_assigned(new_assigned), .survivors(survivors),
`ifdef OPTION_FILTER_STATS_EN
    .dropped(dropped), .stall_cycles(stall_cycles),
`endif
    .unsat(unsat));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_pass(input logic [SIZE-1:0] k, input logic [SIZE-1:0] a, input string tag);
    known = k; assigned = a; start = 1'b1;
    tick;
    start = 1'b0; known = '0; assigned = '0;
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic feed(input logic [SIZE-1:0] d, input logic last, input logic exp_keep, input string tag);
    opt_valid = 1'b1; opt_data = d; opt_last = last;
    #1;
    check({tag, "_rdy"}, opt_ready, 1);
    tick;
    opt_valid = 1'b0; opt_last = 1'b0;
    check({tag, "_kv"}, keep_valid, 1);
    check({tag, "_keep"}, keep, exp_keep);
  endtask

  task automatic finish_pass(input logic [SIZE-1:0] nk, input logic [SIZE-1:0] na, input int surv,
                             input logic un, input string tag);
    int n = 0;
    while (!done && n < 6) begin tick; n++; end
    check({tag, "_done"}, done, 1);
    check({tag, "_nk"}, new_known, nk);
    check({tag, "_na"}, new_assigned, na);
    check({tag, "_surv"}, survivors, surv);
    check({tag, "_unsat"}, unsat, un);
    tick;
    check({tag, "_pulse"}, done, 0);
    check({tag, "_hold"}, survivors, surv);
  endtask

  initial begin
    #12;
    check("rst_kv", keep_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdy", opt_ready, 0);
    rst = 1'b1;
    tick;
    // consistent/contradicting mix, with a start pulse during the pass that must be ignored
    begin_pass(4'b0001, 4'b0001, "s1");
    feed(4'b0011, 1'b0, 1'b1, "s1a");
    start = 1'b1; known = 4'b1111; assigned = 4'b0000;
    feed(4'b0110, 1'b0, 1'b0, "s1b");
    start = 1'b0; known = '0;
    feed(4'b1011, 1'b1, 1'b1, "s1c");
    finish_pass(4'b0111, 4'b0011, 2, 1'b0, "s1");
`ifdef OPTION_FILTER_STATS_EN
    check("s1_dropped", dropped, 1);
`endif
    // every option dropped
    begin_pass(4'b1111, 4'b1010, "s2");
    feed(4'b0101, 1'b0, 1'b0, "s2a");
    feed(4'b0000, 1'b1, 1'b0, "s2b");
    finish_pass(4'b1111, 4'b1010, 0, 1'b1, "s2");
    // survivor counter saturates at 7
    begin_pass(4'b0000, 4'b0000, "sat");
    for (int i = 0; i < 9; i++) feed(4'b0000, i == 8, 1'b1, "sat_o");
    finish_pass(4'b1111, 4'b0000, 7, 1'b0, "sat");
    // downstream stalls for three cycles with an option waiting
    begin_pass(4'b0001, 4'b0001, "bp");
    feed(4'b0011, 1'b0, 1'b1, "bpA");
    keep_ready = 1'b0; opt_valid = 1'b1; opt_data = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall_rdy", opt_ready, 0);
      tick;
      check("bp_hold_kv", keep_valid, 1);
      check("bp_hold_keep", keep, 1);
    end
    keep_ready = 1'b1;
    feed(4'b0110, 1'b0, 1'b0, "bpB");
    feed(4'b1011, 1'b0, 1'b1, "bpC");
    feed(4'b0001, 1'b1, 1'b1, "bpD");
    keep_ready = 1'b0;
    finish_pass(4'b0101, 4'b0001, 3, 1'b0, "bp");
`ifdef OPTION_FILTER_STATS_EN
    check("bp_stalls", stall_cycles, 3);
`endif
    // last verdict still pending after done: start must wait for it
    check("pend_kv", keep_valid, 1);
    check("pend_keep", keep, 1);
    start = 1'b1; known = 4'b0001; assigned = 4'b0001;
    tick;
    check("pend_busy0", busy, 0);
    keep_ready = 1'b1;
    tick;
    check("pend_busy1", busy, 0);
    check("pend_kv_clr", keep_valid, 0);
    tick;
    start = 1'b0; known = '0; assigned = '0;
    check("pend_busy2", busy, 1);
    feed(4'b0011, 1'b1, 1'b1, "pnA");
    finish_pass(4'b1111, 4'b0011, 1, 1'b0, "pn");
    // reset mid-pass clears everything at once
    begin_pass(4'b0001, 4'b0001, "rs");
    feed(4'b0011, 1'b0, 1'b1, "rsA");
    feed(4'b0110, 1'b0, 1'b0, "rsB");
    opt_valid = 1'b1; opt_data = 4'b1011; opt_last = 1'b1;
    rst = 1'b0;
    #1;
    check("mrst_kv", keep_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_rdy", opt_ready, 0);
    check("mrst_nk", new_known, 0);
    check("mrst_na", new_assigned, 0);
    check("mrst_surv", survivors, 0);
    check("mrst_unsat", unsat, 0);
    opt_valid = 1'b0; opt_last = 1'b0;
    rst = 1'b1;
    tick;
    check("mrst_done", done, 0);
    begin_pass(4'b0001, 4'b0001, "r2");
    feed(4'b0011, 1'b0, 1'b1, "r2a");
    feed(4'b0110, 1'b0, 1'b0, "r2b");
    feed(4'b1011, 1'b1, 1'b1, "r2c");
    finish_pass(4'b0111, 4'b0011, 2, 1'b0, "r2");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/option_filter.md
Name: option_filter

Overview:
- Streaming, parametrised successor to the single-option contradiction check for one nonogram line.
- Accepts a burst of candidate options for a line over a valid/ready handshake and returns a registered keep/drop verdict per option, with backpressure.
- Accumulates the cell-wise consensus of all surviving options. At end of burst it reports newly deduced known/assigned cells, the survivor count, and unsatisfiability.
- Sits between the per-line option FIFO and the board state update logic.

Parameters:
SIZE, 8, line length in cells (width of option/known/assigned vectors)
CNT_W, 10, width of survivor counter (saturating)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (rst=0 resets)
start  input  1  begin a line pass; sampled only in IDLE
known  input  SIZE  cells already decided; latched on accepted start
assigned  input  SIZE  values of decided cells; latched on accepted start
opt_valid  input  1  candidate option present
opt_data  input  SIZE  candidate option bits
opt_last  input  1  final option of burst; qualified by opt_valid
opt_ready  output  1  filter accepts option this cycle
keep_valid  output  1  verdict present
keep  output  1  1 = option consistent (retain in FIFO), 0 = contradicts (delete)
keep_ready  input  1  downstream consumes verdict
busy  output  1  state != IDLE
done  output  1  one-cycle pulse, end-of-pass results valid
new_known  output  SIZE  known after deduction; held until next done
new_assigned  output  SIZE  assigned after deduction; held until next done
survivors  output  CNT_W  consistent options this pass; held until next done
unsat  output  1  survivors == 0 at done; held until next done

Behaviour:
- Reset (async, rst=0): state=IDLE; keep_valid=0, keep=0, done=0, busy=0, new_known=0, new_assigned=0, survivors=0, unsat=0; accumulators cleared.
- Reset mid-pass aborts the pass immediately. No done is produced for the aborted pass.
- States: IDLE, FILTER, FINISH.
  - IDLE: start=1 latches known/assigned, sets acc_one=all 1s, acc_zero=all 1s, count=0, then enters FILTER.
  - FILTER: opt_ready = !keep_valid || keep_ready. The transfer is opt_valid && opt_ready.
  - FILTER exits to FINISH on a transfer carrying opt_last.
  - FINISH lasts one cycle. Results are registered and done=1 on the following cycle; the state returns to IDLE.
- Verdict per transfer: contradict = |((assigned ^ opt_data) & known). Next cycle: keep_valid=1, keep=!contradict.
  - keep_valid clears on keep_ready with no new transfer.
  - A simultaneous consume and new transfer gives back-to-back verdicts at full throughput, 1 option/cycle.
  - Latency is 1 cycle from transfer to verdict.
- On a kept option: acc_one &= opt_data; acc_zero &= ~opt_data; count increments.
  - count saturates at 2^CNT_W-1 and never wraps.
- FINISH computation:
  - When count>0:
    - new_known = known | acc_one | acc_zero.
    - new_assigned = (assigned & known) | (acc_one & ~known).
  - When count==0: new_known=known, new_assigned=assigned&known, unsat=1.
  - survivors=count.
- The final verdict may still be pending when done pulses. done does not wait on keep_ready, but the pending verdict is retained until consumed.
- start is ignored outside IDLE. start is also ignored in IDLE while keep_valid=1 (previous verdict not yet consumed); the pass begins once it is consumed.
- opt_valid outside FILTER is ignored (opt_ready=0).
- An empty burst is impossible by protocol; unsat covers all-dropped bursts.
- busy=1 in FILTER and FINISH.

Optional Feature:
- Macro OPTION_FILTER_STATS_EN.
- When defined: adds output dropped[CNT_W-1:0], the saturating count of contradicting options in the pass. It is cleared on start and held with the other results at done.
- Also adds output stall_cycles[15:0], a saturating count of FILTER cycles with opt_valid=1 and opt_ready=0.
- When undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan:
- SIZE=4, known=0001, assigned=0001. Options 0011, 0110, 1011(last), keep_ready=1 -> keep sequence 1,0,1. done: survivors=2, new_known=0111, new_assigned=0011, unsat=0.
- SIZE=4, known=1111, assigned=1010. Options 0101, 0000(last) -> keeps 0,0. done: survivors=0, unsat=1, new_known=1111, new_assigned=1010.
- Backpressure: keep_ready=0 for 3 cycles mid-burst -> opt_ready=0 after one pending verdict, no verdict lost or duplicated. Order preserved on release.
- rst=0 asserted two options into a pass -> all outputs 0 same cycle. Subsequent start gives a clean pass with survivors counted from 0.
- start pulsed while busy=1 -> ignored; pass results unchanged. Back-to-back passes: second start accepted in the cycle after done.
- With OPTION_FILTER_STATS_EN: first scenario -> dropped=1. Holding keep_ready=0 for 2 cycles with opt_valid=1 -> stall_cycles=2.
